vga_timing_gen: RTL and testbench

- Free-running VGA 640x480@60 timing generator that sits directly upstream of the pixel renderers.
- Drives DrawX/DrawY/blank into every renderer.
- Outputs hs/vs delayed so they stay aligned with the renderers' 2-cycle pixel path: sync ROM read, then registered RGB.
- Also provides frame/line strobes and a frame counter for sprite animation and game-tick logic.

---
 rtl/vga_timing_gen.sv | 113 +++++++++++
 tb/tb_vga_timing_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, blank decode, pipelined
// active-low syncs aligned to the renderer's two-stage pixel path, and strobes.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       h_wrap, v_wrap;
  logic       hs_raw, vs_raw;
  logic [10:0] hc_ext, vc_ext;

  assign hc_ext = {1'b0, hc_q};
  assign vc_ext = {1'b0, vc_q};

  always_comb begin
    h_wrap        = (hc_q == 10'(H_TOTAL - 1));
    v_wrap        = (vc_q == 10'(V_TOTAL - 1));
    hc_d          = h_wrap ? '0 : hc_q + 10'd1;
    vc_d          = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + 10'd1;
    end
    // Strobes are computed one clock early so they line up with the (0,*) count.
    line_start_d  = h_wrap;
    frame_start_d = h_wrap && v_wrap;
    frame_count_d = frame_start_d ? frame_count_q + 8'd1 : frame_count_q;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  // 11-bit compares keep the decode correct when a boundary equals 1024.
  always_comb begin
    hs_raw = !((hc_ext >= 11'(HS_START)) && (hc_ext < 11'(HS_END)));
    vs_raw = !((vc_ext >= 11'(VS_START)) && (vc_ext < 11'(VS_END)));
    blank  = (hc_ext < 11'(H_VISIBLE)) && (vc_ext < 11'(V_VISIBLE));
  end

  generate
    if (PIPE_DELAY == 0) begin : g_sync_direct
      assign hs = hs_raw;
      assign vs = vs_raw;
    end else begin : g_sync_pipe
      logic [1:0] sync_pipe_q [PIPE_DELAY];

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
            sync_pipe_q[i] <= '1;
          end
        end else begin
          sync_pipe_q[0] <= {hs_raw, vs_raw};
          for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            sync_pipe_q[i] <= sync_pipe_q[i-1];
          end
        end
      end

      assign hs = sync_pipe_q[PIPE_DELAY-1][1];
      assign vs = sync_pipe_q[PIPE_DELAY-1][0];
    end
  endgenerate

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four instances (default and shrunken rasters,
// several sync delays) compared each cycle against a position-from-clock-count model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  localparam int NI = 4;
  localparam int HV [NI] = '{640, 640, 8, 8};
  localparam int HF [NI] = '{16, 16, 2, 2};
  localparam int HS [NI] = '{96, 96, 3, 3};
  localparam int HB [NI] = '{48, 48, 3, 3};
  localparam int VV [NI] = '{480, 480, 4, 4};
  localparam int VF [NI] = '{10, 10, 1, 1};
  localparam int VS [NI] = '{2, 2, 2, 2};
  localparam int VB [NI] = '{33, 33, 1, 1};
  localparam int PD [NI] = '{2, 0, 0, 3};

  logic [9:0] dx [NI];
  logic [9:0] dy [NI];
  logic       bl [NI];
  logic       hso [NI];
  logic       vso [NI];
  logic       ls [NI];
  logic       fs [NI];
  logic [7:0] fc [NI];

  vga_timing_gen #(.PIPE_DELAY(2)) u_a (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]),
    .hs(hso[0]), .vs(vso[0]), .line_start(ls[0]), .frame_start(fs[0]), .frame_count(fc[0]));

  vga_timing_gen #(.PIPE_DELAY(0)) u_d (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]),
    .hs(hso[1]), .vs(vso[1]), .line_start(ls[1]), .frame_start(fs[1]), .frame_count(fc[1]));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE_DELAY(0)) u_b (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]),
    .hs(hso[2]), .vs(vso[2]), .line_start(ls[2]), .frame_start(fs[2]), .frame_count(fc[2]));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_VISIBLE(4), .V_FP(1),
                   .V_SYNC(2), .V_BP(1), .PIPE_DELAY(3)) u_c (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(dx[3]), .DrawY(dy[3]), .blank(bl[3]),
    .hs(hso[3]), .vs(vso[3]), .line_start(ls[3]), .frame_start(fs[3]), .frame_count(fc[3]));

  // n = clock edges seen since the last reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) n <= 0;
    else          n <= n + 1;
  end

  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d n=%0d got %0d expected %0d", name, i, n, act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    int ht, vt, x, y, m, hx, vy, eh, ev, els, efs, efc, ebl;
    if (!reset_n) begin
      x = 0; y = 0; ebl = 1; eh = 1; ev = 1; els = 0; efs = 0; efc = 0;
    end else begin
      ht  = HV[i] + HF[i] + HS[i] + HB[i];
      vt  = VV[i] + VF[i] + VS[i] + VB[i];
      x   = n % ht;
      y   = (n / ht) % vt;
      ebl = (x < HV[i] && y < VV[i]) ? 1 : 0;
      els = (n > 0 && x == 0) ? 1 : 0;
      efs = (els == 1 && y == 0) ? 1 : 0;
      efc = (n / (ht * vt)) % 256;
      m   = n - PD[i];
      eh  = 1;
      ev  = 1;
      if (m >= 0) begin
        hx = m % ht;
        vy = (m / ht) % vt;
        eh = (hx >= HV[i] + HF[i] && hx < HV[i] + HF[i] + HS[i]) ? 0 : 1;
        ev = (vy >= VV[i] + VF[i] && vy < VV[i] + VF[i] + VS[i]) ? 0 : 1;
      end
    end
    chk("DrawX", i, int'(dx[i]), x);
    chk("DrawY", i, int'(dy[i]), y);
    chk("blank", i, int'(bl[i]), ebl);
    chk("hs", i, int'(hso[i]), eh);
    chk("vs", i, int'(vso[i]), ev);
    chk("line_start", i, int'(ls[i]), els);
    chk("frame_start", i, int'(fs[i]), efs);
    chk("frame_count", i, int'(fc[i]), efc);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) check_inst(i);
    if (reset_n) begin
      // hand-computed anchors pinning the model
      if (n == 639)   chk("lit_blank_639", 0, int'(bl[0]), 1);
      if (n == 640)   chk("lit_blank_640", 0, int'(bl[0]), 0);
      if (n == 657)   chk("lit_hs_657", 0, int'(hso[0]), 1);
      if (n == 658)   chk("lit_hs_658", 0, int'(hso[0]), 0);
      if (n == 753)   chk("lit_hs_753", 0, int'(hso[0]), 0);
      if (n == 754)   chk("lit_hs_754", 0, int'(hso[0]), 1);
      if (n == 655)   chk("lit_hs0_655", 1, int'(hso[1]), 1);
      if (n == 656)   chk("lit_hs0_656", 1, int'(hso[1]), 0);
      if (n == 800) begin
        chk("lit_wrap_x", 0, int'(dx[0]), 0);
        chk("lit_wrap_y", 0, int'(dy[0]), 1);
        chk("lit_wrap_ls", 0, int'(ls[0]), 1);
      end
      if (n == 4799)  chk("lit_l5_x", 0, int'(dx[0]), 799);
      if (n == 4800) begin
        chk("lit_l6_y", 0, int'(dy[0]), 6);
        chk("lit_l6_ls", 0, int'(ls[0]), 1);
      end
      if (n == 4801)  chk("lit_l6_ls_end", 0, int'(ls[0]), 0);
      if (n == 127)   chk("lit_small_fs_127", 2, int'(fs[2]), 0);
      if (n == 128) begin
        chk("lit_small_fs", 2, int'(fs[2]), 1);
        chk("lit_small_fc", 2, int'(fc[2]), 1);
        chk("lit_small_x", 2, int'(dx[2]), 0);
        chk("lit_small_y", 2, int'(dy[2]), 0);
      end
      if (n == 82)    chk("lit_vs_82", 3, int'(vso[3]), 1);
      if (n == 83)    chk("lit_vs_83", 3, int'(vso[3]), 0);
      if (n == 114)   chk("lit_vs_114", 3, int'(vso[3]), 0);
      if (n == 115)   chk("lit_vs_115", 3, int'(vso[3]), 1);
      if (n == 32768) begin
        chk("lit_fc_wrap", 2, int'(fc[2]), 0);
        chk("lit_fc_wrap_fs", 2, int'(fs[2]), 1);
      end
    end
  end

  task automatic release_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    reset_n = 1'b1;
  endtask

  task automatic assert_reset();
    @(negedge clk);
    #($urandom_range(1, 4));
    reset_n = 1'b0;
  endtask

  initial begin
    int waited;
    repeat (5) @(negedge clk);
    release_reset();

    // async reset mid-line at DrawX=300
    waited = 0;
    while (dx[0] != 10'd300 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("wait_x300_timeout", 0, (waited < 2000) ? 1 : 0, 1);
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) check_inst(i);
    repeat (3) @(negedge clk);
    release_reset();

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(500, 6000)) @(negedge clk);
      assert_reset();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      release_reset();
    end

    repeat (33000) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
